seg_frame_decoder: RTL and testbench

- Reverse path of the two-digit seven-segment encoder: takes a 14-bit segment frame {tens[6:0], ones[6:0]} and recovers the 8-bit value 0..99.
- A stability filter rejects glitching or transitional patterns.
- Each settled, newly changed frame is reported once over a valid/ready handshake, with an error flag for patterns that are not digits.
- Used for display loopback checking and for reading externally driven segment buses.

---
 rtl/seg_frame_decoder.sv | 131 +++++++++++++
 tb/tb_seg_frame_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_decoder.sv
// Two-digit seven-segment frame decoder with stability filter and valid/ready output.
// Optional: define SEG_BLANK_LEADING_EN to accept a blank tens digit as 0.
module seg_frame_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] seg_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_value,
  output logic        out_err,
  output logic        overrun
);

  typedef enum logic [1:0] {TRACK, EMIT, WAIT_CHANGE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

`ifdef SEG_BLANK_LEADING_EN
  localparam logic BLANK_TENS_OK = 1'b1;
`else
  localparam logic BLANK_TENS_OK = 1'b0;
`endif

  // Returns {valid, digit}; a blank code is a legal zero only where allowed.
  function automatic logic [4:0] dec_digit(input logic [6:0] pat, input logic blank_ok);
    case (pat)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      7'h00:   return {blank_ok, 4'd0};
      default: return 5'd0;
    endcase
  endfunction

  state_t           state, state_d;
  logic [13:0]      seg_q, last_pat, last_d;
  logic [CNT_W-1:0] cnt;
  logic             have_last, have_last_d;
  logic             valid_d, err_d, overrun_d;
  logic [7:0]       value_d;

  logic       settled;
  logic [4:0] tens_dec, ones_dec;
  logic       frame_err;
  logic [7:0] frame_value;

  assign settled     = (seg_in == seg_q) && (cnt == CNT_MAX);
  assign tens_dec    = dec_digit(seg_q[13:7], BLANK_TENS_OK);
  assign ones_dec    = dec_digit(seg_q[6:0], 1'b0);
  assign frame_err   = !(tens_dec[4] && ones_dec[4]);
  assign frame_value = 8'(tens_dec[3:0]) * 8'd10 + 8'(ones_dec[3:0]);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d     = state;
    valid_d     = out_valid;
    value_d     = out_value;
    err_d       = out_err;
    overrun_d   = 1'b0;
    last_d      = last_pat;
    have_last_d = have_last;
    case (state)
      TRACK: begin
        if (settled) begin
          if (have_last && (seg_q == last_pat)) begin
            state_d = WAIT_CHANGE;
          end else begin
            state_d     = EMIT;
            valid_d     = 1'b1;
            value_d     = frame_err ? 8'hFF : frame_value;
            err_d       = frame_err;
            last_d      = seg_q;
            have_last_d = 1'b1;
          end
        end
      end
      EMIT: begin
        // A frame settling while a result is pending is dropped but remembered.
        if (settled && (seg_q != last_pat)) begin
          overrun_d = 1'b1;
          last_d    = seg_q;
        end
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_CHANGE;
        end
      end
      WAIT_CHANGE: begin
        if (seg_q != last_pat) state_d = TRACK;
      end
      default: state_d = TRACK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TRACK;
      seg_q     <= '0;
      cnt       <= '0;
      last_pat  <= '0;
      have_last <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      seg_q <= seg_in;
      if (seg_in != seg_q)   cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      state     <= state_d;
      last_pat  <= last_d;
      have_last <= have_last_d;
      out_valid <= valid_d;
      out_value <= value_d;
      out_err   <= err_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Self-checking bench for seg_frame_decoder: directed plan plus randomized frames
// compared cycle by cycle against a behavioural model built from run lengths.
module tb_seg_frame_decoder;

  localparam int S = 4;

`ifdef SEG_BLANK_LEADING_EN
  localparam bit BLANK_OK = 1'b1;
`else
  localparam bit BLANK_OK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] seg_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_value;
  logic        out_err;
  logic        overrun;

  seg_frame_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_value(out_value), .out_err(out_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run length of identical samples plus a pending/waiting mode.
  logic [13:0] m_prev, m_last;
  int          m_run, m_mode;   // mode 0 = looking, 1 = result pending, 2 = waiting for change
  logic        m_valid, m_err, m_ovr, m_have;
  logic [7:0]  m_value;

  logic [8:0] acc_q[$];   // {err, value} accepted by the DUT
  int n_ovr = 0;

  function automatic logic [4:0] mdig(input logic [6:0] p, input bit is_tens);
    logic [6:0] codes[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    for (int i = 0; i < 10; i++) if (p == codes[i]) return {1'b1, 4'(i)};
    if (is_tens && BLANK_OK && p == 7'h00) return 5'h10;
    return 5'h00;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_last = '0; m_run = 0; m_mode = 0;
    m_valid = 0; m_err = 0; m_ovr = 0; m_have = 0; m_value = '0;
  endtask

  task automatic model_edge(input logic [13:0] seg, input logic rdy);
    bit settled, accept;
    logic [4:0] t, o;
    settled = (seg == m_prev) && (m_run >= S - 1);
    accept  = m_valid && rdy;
    m_ovr   = 0;
    case (m_mode)
      0: if (settled) begin
        if (m_have && m_prev == m_last) m_mode = 2;
        else begin
          t = mdig(m_prev[13:7], 1'b1);
          o = mdig(m_prev[6:0], 1'b0);
          m_err   = !(t[4] && o[4]);
          m_value = m_err ? 8'hFF : 8'(int'(t[3:0]) * 10 + int'(o[3:0]));
          m_valid = 1; m_last = m_prev; m_have = 1; m_mode = 1;
        end
      end
      1: begin
        if (settled && m_prev != m_last) begin m_ovr = 1; m_last = m_prev; end
        if (accept) begin m_valid = 0; m_mode = 2; end
      end
      default: if (m_prev != m_last) m_mode = 0;
    endcase
    if (seg != m_prev) m_run = 0;
    else if (m_run < 1000) m_run++;
    m_prev = seg;
  endtask

  // One clock: drive at the falling edge, compare 1 ns after the rising edge.
  task automatic tick(input logic [13:0] seg, input logic rdy);
    seg_in = seg;
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) acc_q.push_back({out_err, out_value});
    @(posedge clk);
    model_edge(seg, rdy);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (m_valid) begin
      check("out_value", 32'(out_value), 32'(m_value));
      check("out_err", 32'(out_err), 32'(m_err));
    end
    if (overrun) n_ovr++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [13:0] seg, input logic rdy, input int n);
    for (int i = 0; i < n; i++) tick(seg, rdy);
  endtask

  function automatic logic [6:0] rand_pat();
    logic [6:0] codes[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int r = $urandom_range(0, 9);
    if (r < 7) return codes[$urandom_range(0, 9)];
    if (r == 7) return 7'h00;
    return 7'($urandom);
  endfunction

  initial begin
    int first_i, n0;
    logic [8:0] last_acc;

    model_reset();
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_value", 32'(out_value), 32'd0);
    check("reset_err", 32'(out_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // First frame {3,4}: valid rises S edges after first capture.
    first_i = -1;
    for (int i = 0; i < 10; i++) begin
      tick({7'h4F, 7'h66}, 1'b1);
      if (out_valid && first_i < 0) first_i = i;
    end
    check("first_latency", 32'(first_i), 32'd4);
    check("count_34", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("value_34", 32'(acc_q[0]), 32'h022);

    hold({7'h4F, 7'h66}, 1'b1, 50);
    check("no_repeat", 32'(acc_q.size()), 32'd1);
    hold({7'h6F, 7'h6F}, 1'b1, 10);
    check("count_99", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() > 1) check("value_99", 32'(acc_q[1]), 32'h063);

    // Short glitch between identical stable frames.
    hold({7'h06, 7'h5B}, 1'b1, 10);
    hold({7'h7F, 7'h3F}, 1'b1, 2);
    hold({7'h06, 7'h5B}, 1'b1, 10);
    check("count_glitch", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() > 2) check("value_12", 32'(acc_q[2]), 32'h00C);
    check("glitch_no_ovr", 32'(n_ovr), 32'd0);

    hold({7'h12, 7'h06}, 1'b1, 10);
    check("bad_digit", 32'(acc_q[acc_q.size()-1]), 32'h1FF);
    hold({7'h00, 7'h6D}, 1'b1, 10);
    check("blank_tens", 32'(acc_q[acc_q.size()-1]), BLANK_OK ? 32'h005 : 32'h1FF);

    // Overrun while a result is held.
    hold({7'h06, 7'h06}, 1'b0, 6);
    hold({7'h5B, 7'h5B}, 1'b0, 8);
    check("ovr_count", 32'(n_ovr), 32'd1);
    check("held_value", 32'(out_value), 32'd11);
    n0 = acc_q.size();
    hold({7'h5B, 7'h5B}, 1'b1, 12);
    check("ovr_accepts", 32'(acc_q.size() - n0), 32'd1);
    check("ovr_accept_val", 32'(acc_q[acc_q.size()-1]), 32'h00B);

    // Reset while a result is pending; the same frame must be reported again.
    hold({7'h3F, 7'h06}, 1'b0, 6);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_value", 32'(out_value), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = acc_q.size();
    hold({7'h3F, 7'h06}, 1'b1, 10);
    check("rereport_count", 32'(acc_q.size() - n0), 32'd1);
    check("rereport_val", 32'(acc_q[acc_q.size()-1]), 32'h001);

    // Randomized frames, hold times and consumer back-pressure.
    for (int f = 0; f < 1200; f++) begin
      logic [13:0] fr;
      int len;
      fr  = {rand_pat(), rand_pat()};
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 3) == 0) fr = m_prev;
      for (int c = 0; c < len; c++) tick(fr, 1'(($urandom_range(0, 2) != 0)));
    end
    hold(seg_in, 1'b1, 10);
    check("drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
